// File: rtl/seg_capture_decoder_pkg.sv
// Shared definitions for the seven-segment capture decoder.
// Segment codes are active-low, bit0 = a ... bit6 = g.
// SEG_CODE_BLANK is only meaningful when SEG_BLANK_DETECT_EN is defined.
package seg_capture_decoder_pkg;

    localparam logic [6:0] SEG_CODE_0     = 7'h40;
    localparam logic [6:0] SEG_CODE_1     = 7'h79;
    localparam logic [6:0] SEG_CODE_2     = 7'h24;
    localparam logic [6:0] SEG_CODE_3     = 7'h30;
    localparam logic [6:0] SEG_CODE_4     = 7'h19;
    localparam logic [6:0] SEG_CODE_5     = 7'h12;
    localparam logic [6:0] SEG_CODE_6     = 7'h02;
    localparam logic [6:0] SEG_CODE_7     = 7'h78;
    localparam logic [6:0] SEG_CODE_8     = 7'h00;
    localparam logic [6:0] SEG_CODE_9     = 7'h10;
    localparam logic [6:0] SEG_CODE_A     = 7'h08;
    localparam logic [6:0] SEG_CODE_B     = 7'h03;
    localparam logic [6:0] SEG_CODE_C     = 7'h46;
    localparam logic [6:0] SEG_CODE_D     = 7'h21;
    localparam logic [6:0] SEG_CODE_E     = 7'h06;
    localparam logic [6:0] SEG_CODE_F     = 7'h0E;
    localparam logic [6:0] SEG_CODE_BLANK = 7'h7F;

    // Capture FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern lookup.
// Returns the hex value of a legal code and a legal flag; anything else
// (including the blank code) is reported as not legal.
module seg_pattern_decode
    import seg_capture_decoder_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_legal
);

    // Table lookup of the sixteen legal segment codes
    always_comb begin
        o_value = 4'h0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_CODE_0: o_value = 4'h0;
            SEG_CODE_1: o_value = 4'h1;
            SEG_CODE_2: o_value = 4'h2;
            SEG_CODE_3: o_value = 4'h3;
            SEG_CODE_4: o_value = 4'h4;
            SEG_CODE_5: o_value = 4'h5;
            SEG_CODE_6: o_value = 4'h6;
            SEG_CODE_7: o_value = 4'h7;
            SEG_CODE_8: o_value = 4'h8;
            SEG_CODE_9: o_value = 4'h9;
            SEG_CODE_A: o_value = 4'hA;
            SEG_CODE_B: o_value = 4'hB;
            SEG_CODE_C: o_value = 4'hC;
            SEG_CODE_D: o_value = 4'hD;
            SEG_CODE_E: o_value = 4'hE;
            SEG_CODE_F: o_value = 4'hF;
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture_decoder.sv
// Multiplexed seven-segment display snooper.
// Registers {SegIn, AnodeIn} once, waits for STABLE_CYCLES identical samples
// on a single active digit, then captures the decoded value into that digit's
// slice and posts a one-entry change event.
// Optional feature: define SEG_BLANK_DETECT_EN to treat code 7F as a legal
// blank that clears DigitValid without flagging an error.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no single digit enabled in the sample, nothing tracked
// ST_SETTLE | tracking a pattern, r_cnt = identical samples seen so far
// ST_LOCKED | pattern captured, holding until the sample changes
module seg_capture_decoder
    import seg_capture_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [6:0]              SegIn,
    input  logic [NUM_DIGITS-1:0]   AnodeIn,
    output logic [4*NUM_DIGITS-1:0] DigitsOut,
    output logic [NUM_DIGITS-1:0]   DigitValid,
    output logic                    EvtValid,
    input  logic                    EvtReady,
    output logic [2:0]              EvtPos,
    output logic [3:0]              EvtDigit,
    output logic                    ErrSticky,
    output logic                    OvfSticky
);

    localparam logic [7:0]            LP_STABLE = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] LP_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [6:0]              r_seg_samp;
    logic [NUM_DIGITS-1:0]   r_anode_samp;
    logic [6:0]              r_seg_ref;
    logic [NUM_DIGITS-1:0]   r_anode_ref;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_nxt;
    logic                    w_load_ref;
    logic                    w_capture;

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_err;
    logic                    r_evt_valid;
    logic [2:0]              r_evt_pos;
    logic [3:0]              r_evt_digit;
    logic                    r_ovf;

    logic [NUM_DIGITS-1:0]   w_anode_low;
    logic                    w_one_low;
    logic                    w_same;
    logic [2:0]              w_pos;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_valid;
    logic [3:0]              w_dec_value;
    logic                    w_dec_legal;
    logic                    w_is_blank;
    logic                    w_evt_gen;

    assign w_anode_low = ~r_anode_samp;
    assign w_one_low   = (w_anode_low != '0) &&
                         ((w_anode_low & (w_anode_low - LP_ONE)) == '0);
    assign w_same      = (r_seg_samp == r_seg_ref) && (r_anode_samp == r_anode_ref);

    seg_pattern_decode u_decode (
        .i_seg   (r_seg_samp),
        .o_value (w_dec_value),
        .o_legal (w_dec_legal)
    );

`ifdef SEG_BLANK_DETECT_EN
    assign w_is_blank = (r_seg_samp == SEG_CODE_BLANK);
`else
    assign w_is_blank = 1'b0;
`endif

    // Input sample register; reset to all-ones so no digit appears enabled
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_seg_samp   <= '1;
            r_anode_samp <= '1;
        end else begin
            r_seg_samp   <= SegIn;
            r_anode_samp <= AnodeIn;
        end
    end

    // FSM state, stability counter and the reference pattern being tracked
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_seg_ref   <= '1;
            r_anode_ref <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_ref) begin
                r_seg_ref   <= r_seg_samp;
                r_anode_ref <= r_anode_samp;
            end
        end
    end

    // Next state: any new pattern restarts the count at one sample seen
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_ref  = 1'b0;
        w_capture   = 1'b0;
        if (!w_one_low) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (w_same) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        if (w_cnt_nxt == LP_STABLE) begin
                            w_state_nxt = ST_LOCKED;
                            w_capture   = 1'b1;
                        end
                    end else begin
                        w_load_ref  = 1'b1;
                        w_cnt_nxt   = 8'd1;
                        w_state_nxt = (LP_STABLE == 8'd1) ? ST_LOCKED : ST_SETTLE;
                        w_capture   = (LP_STABLE == 8'd1);
                    end
                end
                ST_LOCKED: begin
                    if (!w_same) begin
                        w_load_ref  = 1'b1;
                        w_cnt_nxt   = 8'd1;
                        w_state_nxt = (LP_STABLE == 8'd1) ? ST_LOCKED : ST_SETTLE;
                        w_capture   = (LP_STABLE == 8'd1);
                    end
                end
                default: begin
                    w_load_ref  = 1'b1;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = (LP_STABLE == 8'd1) ? ST_LOCKED : ST_SETTLE;
                    w_capture   = (LP_STABLE == 8'd1);
                end
            endcase
        end
    end

    // Select the enabled digit's position and currently stored contents
    always_comb begin
        w_pos       = '0;
        w_cur_digit = '0;
        w_cur_valid = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_anode_low[i]) begin
                w_pos       = 3'(i);
                w_cur_digit = r_digits[4*i +: 4];
                w_cur_valid = r_valid[i];
            end
        end
    end

    assign w_evt_gen = w_capture && w_dec_legal &&
                       (!w_cur_valid || (w_cur_digit != w_dec_value));

    // Digit store: legal codes update the slice, others only clear valid
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_err    <= 1'b0;
        end else if (w_capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_anode_low[i]) begin
                    if (w_dec_legal) begin
                        r_digits[4*i +: 4] <= w_dec_value;
                        r_valid[i]         <= 1'b1;
                    end else begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
            if (!w_dec_legal && !w_is_blank) begin
                r_err <= 1'b1;
            end
        end
    end

    // One-entry event buffer; a slot freed this cycle may be refilled at once
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_evt_valid <= 1'b0;
            r_evt_pos   <= '0;
            r_evt_digit <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_evt_gen && (!r_evt_valid || EvtReady)) begin
                r_evt_valid <= 1'b1;
                r_evt_pos   <= w_pos;
                r_evt_digit <= w_dec_value;
            end else if (r_evt_valid && EvtReady) begin
                r_evt_valid <= 1'b0;
            end
            if (w_evt_gen && r_evt_valid && !EvtReady) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign DigitsOut  = r_digits;
    assign DigitValid = r_valid;
    assign EvtValid   = r_evt_valid;
    assign EvtPos     = r_evt_pos;
    assign EvtDigit   = r_evt_digit;
    assign ErrSticky  = r_err;
    assign OvfSticky  = r_ovf;

endmodule

// File: doc/seg_capture_decoder.md
SEG_CAPTURE_DECODER -- requirements
Module: seg_capture_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions (2..8).
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical-sample cycles required before a pattern is accepted (1..255).
REQ-003 Clk  input  1  sole clock, all state on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 SegIn  input  7  active-low segment lines, bit0=a ... bit6=g.
REQ-006 AnodeIn  input  NUM_DIGITS  active-low digit enables; valid only when exactly one bit is low.
REQ-007 DigitsOut  output  4*NUM_DIGITS  last accepted hex value per position, position p in bits [4p+3:4p].
REQ-008 DigitValid  output  NUM_DIGITS  per-position flag: DigitsOut slice holds a legally decoded value.
REQ-009 EvtValid  output  1  change event pending.
REQ-010 EvtReady  input  1  consumer accepts event when EvtValid and EvtReady are both high on a rising edge.
REQ-011 EvtPos  output  3  position of pending event.
REQ-012 EvtDigit  output  4  decoded value of pending event.
REQ-013 ErrSticky  output  1  an accepted pattern was not a legal code.
REQ-014 OvfSticky  output  1  a change event was dropped.

Function
REQ-015 Legal codes (SegIn hex -> value) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-016 FSM SHALL have states IDLE, SETTLE, LOCKED; {SegIn, AnodeIn} is registered once, and comparisons use that sample.
REQ-017 IDLE: when the sample has exactly one anode low -> SETTLE, stability counter = 1.
REQ-018 SETTLE: identical sample -> counter increments; when counter reaches STABLE_CYCLES -> LOCKED and capture occurs; changed sample -> counter = 1, remain SETTLE; zero/multiple anodes low -> IDLE.
REQ-019 LOCKED: identical sample -> hold, no further capture; any change -> SETTLE (counter = 1) or IDLE per REQ-017/018.
REQ-020 Capture of legal code: slice p updated, DigitValid[p] set; if value differs from stored slice or DigitValid[p] was 0, a change event is generated.
REQ-021 Capture of illegal code: DigitValid[p] cleared, slice unchanged, ErrSticky set, no event.
REQ-022 Event buffer SHALL be one entry; event generated while empty or while the current entry is accepted the same cycle -> loaded, EvtValid high next cycle.
REQ-023 Event generated while full and not accepted -> new event dropped, OvfSticky set, held entry unchanged.
REQ-024 Latency: capture-to-EvtValid one cycle; SegIn change to capture = STABLE_CYCLES+1 cycles minimum.
REQ-025 ErrSticky and OvfSticky SHALL clear only on reset.

Reset
REQ-026 Rst high SHALL immediately force: state IDLE, counter 0, DigitsOut 0, DigitValid 0, EvtValid 0, EvtPos 0, EvtDigit 0, ErrSticky 0, OvfSticky 0, sample register all-ones.
REQ-027 Reset mid-SETTLE or with pending event SHALL discard both; first capture after release requires full STABLE_CYCLES.

Configuration
REQ-028 Macro SEG_BLANK_DETECT_EN defined: SegIn 7F is a legal blank capture that clears DigitValid[p] without setting ErrSticky and generates no event.
REQ-029 Macro undefined: 7F is treated as illegal per REQ-021.

Structure
REQ-030 Shared package SHALL hold the 16 segment code constants, the blank code 7F and the FSM state encoding.
REQ-031 Combinational lookup SHALL be sub-module seg_pattern_decode (7-bit in; 4-bit value and legal flag out); the FSM, counter and event buffer reside in the top.

Verification
REQ-032 STABLE_CYCLES=4, AnodeIn=1110, SegIn=24 held 6 cycles -> DigitsOut[3:0]=2, DigitValid[0]=1, one EvtValid pulse with EvtPos=0, EvtDigit=2.
REQ-033 SegIn toggling 24/30 every 2 cycles -> no capture, no event, DigitValid unchanged.
REQ-034 AnodeIn=1100 with SegIn=40 held 10 cycles -> FSM stays IDLE, outputs unchanged.
REQ-035 SegIn=55 stable on position 1 -> ErrSticky=1, DigitValid[1]=0, no event.
REQ-036 EvtReady=0, captures on positions 0 then 1 with differing values -> first event held, OvfSticky=1; assert EvtReady -> position-0 event accepted.
REQ-037 Rst pulsed during SETTLE on position 2 -> all outputs zero immediately; capture occurs only after 4 further stable cycles.
